spi_sram_cache: RTL and testbench
=================================

Name: spi_sram_cache

Overview:
- Direct-mapped, write-through, byte-line read cache between the cpu_6502 bus and spi_sram_master.
- Read hits complete in zero wait cycles; misses, writes and uncached accesses are forwarded as single-byte SPI SRAM transactions.
- Reduces SPI traffic for instruction and zero-page fetches.
- Includes a flush sequencer and saturating hit/miss counters for bench statistics.

Parameters:
- LINES, 16, number of cache lines; power of two, 2..256; IDX_W = log2(LINES).
- NC_LO, 16'h0200, first address of the uncached window (inclusive).
- NC_HI, 16'h02FF, last address of the uncached window (inclusive).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cpu_en  in  1  CPU request valid.
- cpu_addr  in  16  CPU byte address; held stable while cpu_rdy=0.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data; valid in the cycle cpu_rdy=1.
- cpu_rdy  out  1  request completes this cycle.
- flush  in  1  single-cycle pulse; invalidates all lines.
- mem_addr  out  24  {8'h00, latched address} to spi_sram_master.
- mem_en  out  1  downstream request valid.
- mem_wr  out  1  downstream write.
- mem_wdata  out  8  downstream write data.
- mem_rdata  in  8  downstream read data; valid when mem_ready=1.
- mem_ready  in  1  downstream transaction completes this cycle.
- hit_cnt  out  16  saturating read-hit counter.
- miss_cnt  out  16  saturating forwarded-request counter.

Behaviour:
- Address split: index = cpu_addr[IDX_W-1:0], tag = cpu_addr[15:IDX_W].
- Hit = valid[index] and tag match and address outside [NC_LO, NC_HI].
- Reset values: state IDLE; all valid bits 0; mem_en 0; cpu_rdy 0; cpu_rdata 8'h00; counters 0; flush_pend 0. The tag/data array is not reset.
- State IDLE:
  - cpu_en && !cpu_wr && hit: cpu_rdy=1 combinationally in the same cycle; cpu_rdata = data[index]; hit_cnt increments.
  - Any other request with cpu_en: latch addr/wr/wdata into request registers, go to BUSY, cpu_rdy=0.
  - flush (or flush_pend) with no cpu_en: go to FLUSH.
- State BUSY:
  - mem_en=1; mem_addr/mem_wr/mem_wdata are driven only from the request registers and are stable until mem_ready.
  - On mem_ready: cpu_rdy=1 the same cycle; for a read, cpu_rdata = mem_rdata.
  - Cacheable read: fill the line (valid=1, tag, data=mem_rdata).
  - Cacheable write (write-allocate): line valid=1, tag, data=wdata.
  - Uncached accesses never touch the array.
  - miss_cnt increments; return to IDLE, or go to FLUSH if flush_pend.
- mem_ready outside BUSY is ignored.
- State FLUSH:
  - Counter clears valid[0..LINES-1], one line per cycle; cpu_rdy=0; mem_en=0.
  - Exactly LINES cycles, then IDLE; flush_pend cleared.
- flush arriving in BUSY, or in IDLE together with a miss: set flush_pend; FLUSH runs after the current transaction completes.
- flush arriving in IDLE together with a read hit: the hit completes that cycle and FLUSH starts next cycle.
- flush arriving in FLUSH: ignored, no restart.
- Minimum miss latency: 1 cycle + downstream latency. The CPU-visible completion cycle equals the mem_ready cycle.
- Counters saturate at 16'hFFFF.
- rst asserted mid-BUSY: mem_en drops immediately (asynchronously) and no line is written.

Decomposition:
- spi_sram_cache_pkg holds:
  - cache_state_t enum {IDLE, BUSY, FLUSH};
  - request struct {addr[15:0], wr, wdata[7:0]};
  - function in_nc_window(addr).
- One sub-module, spi_sram_cache_array: valid/tag/data storage.
  - Asynchronous read port by index.
  - Single write port.
  - Per-line valid clear for the flush sweep.
  - Async reset of the valid bits.

Test Plan:
- Cold read 16'h0400 with downstream data 8'hA9 -> mem_en asserted one cycle after the request, cpu_rdata=8'hA9 with cpu_rdy=1 on mem_ready, miss_cnt=1. Repeat the read -> cpu_rdy=1 in the same cycle, no mem_en, hit_cnt=1.
- Read 16'h0400, then read 16'h0410 (same index at LINES=16, different tag) -> second read forwarded. Re-read 16'h0400 -> forwarded again (eviction).
- Write 8'h5A to 16'h0401 -> mem_wr=1, mem_wdata=8'h5A, mem_addr=24'h000401. Subsequent read -> hit returning 8'h5A.
- Read 16'h0200 twice (uncached window) -> both forwarded; hit_cnt unchanged; miss_cnt +2.
- flush pulse while BUSY on 16'h0500 -> transaction completes, then exactly 16 cycles of cpu_rdy=0. Re-read 16'h0500 -> forwarded.
- Assert rst while BUSY with mem_ready held low -> mem_en=0 immediately; after release, read of the same address -> forwarded, counters=0.

Source files
------------

// File: rtl/spi_sram_cache_pkg.sv
// spi_sram_cache_pkg: shared FSM state, request record and uncached-window test for spi_sram_cache
package spi_sram_cache_pkg;
  localparam logic [15:0] NC_LO_DEF = 16'h0200;
  localparam logic [15:0] NC_HI_DEF = 16'h02FF;
  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} cache_state_t;
  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  wdata;
  } request_t;
  function automatic logic in_nc_window(input logic [15:0] addr, input logic [15:0] lo = NC_LO_DEF,
                                        input logic [15:0] hi = NC_HI_DEF);
    return addr >= lo && addr <= hi;
  endfunction
endpackage

// File: rtl/spi_sram_cache_array.sv
// spi_sram_cache_array: valid/tag/data line store; async read by rd_idx, one write port (we/wr_*), per-line valid clear (clr/clr_idx), async-reset valid bits
module spi_sram_cache_array #(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 16 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [7:0]       rd_data,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [7:0]       wr_data,
  input  logic             clr,
  input  logic [IDX_W-1:0] clr_idx
);
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [7:0]       data [LINES];
  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];
  always_ff @(posedge clk or posedge rst)
    if (rst) valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
    else if (clr) valid[clr_idx] <= 1'b0;
  always_ff @(posedge clk)
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
endmodule

// File: rtl/spi_sram_cache.sv
// spi_sram_cache: direct-mapped write-through byte cache; cpu_* request side, mem_* single-byte SPI SRAM side, flush pulse, saturating hit_cnt/miss_cnt
module spi_sram_cache
  import spi_sram_cache_pkg::*;
#(
  parameter int          LINES = 16,
  parameter logic [15:0] NC_LO = 16'h0200,
  parameter logic [15:0] NC_HI = 16'h02FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  input  logic        flush,
  output logic [23:0] mem_addr,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 16 - IDX_W;
  cache_state_t     state, state_d;
  request_t         req;
  logic             flush_pend;
  logic [IDX_W-1:0] cnt;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [7:0]       rd_data;
  logic             hit, rd_hit, done, go_flush;
  assign hit      = rd_valid && rd_tag == cpu_addr[15:IDX_W] && !in_nc_window(cpu_addr, NC_LO, NC_HI);
  assign rd_hit   = state == IDLE && cpu_en && !cpu_wr && hit;
  assign done     = state == BUSY && mem_ready;
  assign go_flush = flush || flush_pend;
  assign cpu_rdy   = rd_hit || done;
  assign cpu_rdata = rd_hit ? rd_data : (done && !req.wr) ? mem_rdata : 8'h00;
  assign mem_en    = state == BUSY;
  assign mem_addr  = {8'h00, req.addr};
  assign mem_wr    = req.wr;
  assign mem_wdata = req.wdata;
  always_comb begin
    state_d = state;
    if (state == IDLE) state_d = (cpu_en && !rd_hit) ? BUSY : go_flush ? FLUSH : IDLE;
    else if (state == BUSY) state_d = mem_ready ? (go_flush ? FLUSH : IDLE) : BUSY;
    else state_d = (cnt == IDX_W'(LINES - 1)) ? IDLE : FLUSH;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req        <= '0;
      flush_pend <= 1'b0;
      cnt        <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      if (state == IDLE && cpu_en && !rd_hit) req <= '{addr: cpu_addr, wr: cpu_wr, wdata: cpu_wdata};
      flush_pend <= (state == FLUSH) ? 1'b0 : flush_pend | (flush && state_d == BUSY);
      cnt        <= (state == FLUSH) ? cnt + IDX_W'(1) : '0;
      if (rd_hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      if (done && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
    end
  spi_sram_cache_array #(.LINES(LINES)) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (cpu_addr[IDX_W-1:0]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .we      (done && !in_nc_window(req.addr, NC_LO, NC_HI)),
    .wr_idx  (req.addr[IDX_W-1:0]),
    .wr_tag  (req.addr[15:IDX_W]),
    .wr_data (req.wr ? req.wdata : mem_rdata),
    .clr     (state == FLUSH),
    .clr_idx (cnt)
  );
endmodule

// File: tb/tb_spi_sram_cache.sv
// tb_spi_sram_cache: directed scoreboard bench for spi_sram_cache with a one-wait-cycle SRAM responder
module tb_spi_sram_cache;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cpu_en = 1'b0, cpu_wr = 1'b0, flush = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0, cpu_rdata;
  logic        cpu_rdy;
  logic [23:0] mem_addr;
  logic        mem_en, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] hit_cnt, miss_cnt;
  int total = 0, passed = 0;
  typedef struct {bit fwd; bit rd; logic [7:0] data; string name;} exp_t;
  exp_t exp_q[$];
  logic [7:0] sram [0:65535];
  bit hold = 1'b0;
  int wait_cnt = 0;
  localparam int LAT = 1;
  int cyc;
  logic en1, en2, cap_wr;
  logic [23:0] cap_addr;
  logic [7:0] cap_wdata;

  spi_sram_cache dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy), .flush(flush),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk)
    if (cpu_rdy === 1'b1) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_rdy: got cpu_rdy=1 expected no completion");
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_fwd"}, 32'(mem_en), 32'(e.fwd));
        if (e.rd) check({e.name, "_rdata"}, 32'(cpu_rdata), 32'(e.data));
      end
    end

  initial forever begin
    @(posedge clk);
    #1;
    if (mem_ready) mem_ready = 1'b0;
    else if (mem_en && !hold) begin
      if (wait_cnt == LAT) begin
        mem_ready = 1'b1;
        mem_rdata = sram[mem_addr[15:0]];
        if (mem_wr) sram[mem_addr[15:0]] = mem_wdata;
        wait_cnt = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  task automatic access(input string name, input logic [15:0] a, input logic w, input logic [7:0] wd,
                        input bit fwd, input logic [7:0] exp_rd, input int exp_cyc);
    exp_q.push_back('{fwd, !w, exp_rd, name});
    cpu_en = 1'b1; cpu_addr = a; cpu_wr = w; cpu_wdata = wd; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) en1 = mem_en;
      if (cyc == 2) begin
        en2 = mem_en; cap_addr = mem_addr; cap_wr = mem_wr; cap_wdata = mem_wdata;
      end
    end while (cpu_rdy !== 1'b1 && cyc < 60);
    check({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    @(posedge clk);
    #1 cpu_en = 1'b0; cpu_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    sram[16'h0400] = 8'hA9; sram[16'h0410] = 8'h3C; sram[16'h0401] = 8'h11;
    sram[16'h0200] = 8'h77; sram[16'h0500] = 8'hE1; sram[16'h0600] = 8'hC3;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rdy", 32'(cpu_rdy), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_rdata", 32'(cpu_rdata), 0);
    check("rst_hit_cnt", 32'(hit_cnt), 0);
    check("rst_miss_cnt", 32'(miss_cnt), 0);
    @(posedge clk);
    #1;
    access("cold", 16'h0400, 1'b0, 8'h00, 1'b1, 8'hA9, 3);
    check("cold_en_req_cycle", 32'(en1), 0);
    check("cold_en_next_cycle", 32'(en2), 1);
    check("cold_miss_cnt", 32'(miss_cnt), 1);
    access("hit", 16'h0400, 1'b0, 8'h00, 1'b0, 8'hA9, 1);
    check("hit_hit_cnt", 32'(hit_cnt), 1);
    check("hit_miss_cnt", 32'(miss_cnt), 1);
    access("ev_hit", 16'h0400, 1'b0, 8'h00, 1'b0, 8'hA9, 1);
    access("ev_other", 16'h0410, 1'b0, 8'h00, 1'b1, 8'h3C, 3);
    access("ev_back", 16'h0400, 1'b0, 8'h00, 1'b1, 8'hA9, 3);
    access("wr", 16'h0401, 1'b1, 8'h5A, 1'b1, 8'h00, 3);
    check("wr_mem_addr", 32'(cap_addr), 32'h000401);
    check("wr_mem_wr", 32'(cap_wr), 1);
    check("wr_mem_wdata", 32'(cap_wdata), 32'h5A);
    access("wr_hit", 16'h0401, 1'b0, 8'h00, 1'b0, 8'h5A, 1);
    access("nc1", 16'h0200, 1'b0, 8'h00, 1'b1, 8'h77, 3);
    access("nc2", 16'h0200, 1'b0, 8'h00, 1'b1, 8'h77, 3);
    check("nc_hit_cnt", 32'(hit_cnt), 3);
    check("nc_miss_cnt", 32'(miss_cnt), 6);
    fork
      access("fl_busy", 16'h0500, 1'b0, 8'h00, 1'b1, 8'hE1, 3);
      begin
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
    join
    access("fl_reread", 16'h0500, 1'b0, 8'h00, 1'b1, 8'hE1, 19);
    access("fl_line1", 16'h0401, 1'b0, 8'h00, 1'b1, 8'h5A, 3);
    check("fl_hit_cnt", 32'(hit_cnt), 3);
    check("fl_miss_cnt", 32'(miss_cnt), 9);
    hold = 1'b1;
    cpu_en = 1'b1; cpu_addr = 16'h0600; cpu_wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rb_busy_en", 32'(mem_en), 1);
    #1 rst = 1'b1;
    #1 check("rb_en_async_drop", 32'(mem_en), 0);
    cpu_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0; hold = 1'b0;
    @(negedge clk);
    check("rb_hit_cnt", 32'(hit_cnt), 0);
    check("rb_miss_cnt", 32'(miss_cnt), 0);
    @(posedge clk);
    #1;
    access("rb_after", 16'h0600, 1'b0, 8'h00, 1'b1, 8'hC3, 3);
    check("rb_after_miss_cnt", 32'(miss_cnt), 1);
    check("rb_after_hit_cnt", 32'(hit_cnt), 0);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
